mirfak_csr_arbiter: RTL

Shares the single CSR-file access port between the pipeline's CSR instructions and a debug/host requester. The pipeline always has priority. Debug accesses are granted only when the pipeline presents no CSR command and no trap or xret is retiring. A starvation counter stalls the pipeline so that a pending debug request is eventually served. The block sits between the writeback-stage CSR signals, the debug transport and `mirfak_csr`.

---
 rtl/mirfak_csr_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mirfak_csr_arbiter.sv
// mirfak_csr_arbiter: shares the single CSR-file port between the pipeline's
// writeback-stage CSR instructions and a debug/host requester. The pipeline
// always wins; a starvation counter eventually stalls it so that a pending
// debug request is served. Debug reads are issued as csrrs x0 so read-only
// and nonexistent CSRs are checked exactly as a pipeline read would be.
module mirfak_csr_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic [11:0] pipe_csr_addr_i,
    input  logic [1:0]  pipe_csr_cmd_i,
    input  logic        pipe_csr_rs1_zero_i,
    input  logic [31:0] pipe_csr_wdata_i,
    output logic [31:0] pipe_csr_rdata_o,
    output logic        pipe_csr_exception_o,
    output logic        pipe_stall_o,
    input  logic        wb_trap_i,

    input  logic        dbg_req_i,
    input  logic [11:0] dbg_addr_i,
    input  logic [1:0]  dbg_cmd_i,
    input  logic [31:0] dbg_wdata_i,
    output logic        dbg_ack_o,
    output logic [31:0] dbg_rdata_o,
    output logic        dbg_err_o,

    output logic [11:0] csr_addr_o,
    output logic [1:0]  csr_cmd_o,
    output logic        csr_rs1_zero_o,
    output logic [31:0] csr_wdata_o,
    input  logic [31:0] csr_rdata_i,
    input  logic        csr_exception_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    // Pipeline command encoding shared with the CSR file.
    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_SET   = 2'b10;
    // Debug command encoding: 00 means read.
    localparam logic [1:0] DBG_READ  = 2'b00;

    state_e      state_q, state_d;
    logic [11:0] dbg_addr_q, dbg_addr_d;
    logic [1:0]  dbg_cmd_q, dbg_cmd_d;
    logic [31:0] dbg_wdata_q, dbg_wdata_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;
    logic        dbg_err_q, dbg_err_d;
    logic [7:0]  starve_cnt_q, starve_cnt_d;
    logic        starve_q, starve_d;

    logic        grant;
    logic        dbg_is_read;

    // The debug side only gets the port when the pipeline leaves it free and
    // nothing is retiring a trap/xret that could change CSR state this cycle.
    assign grant       = (state_q == IDLE) && dbg_req_i &&
                         (pipe_csr_cmd_i == CMD_NONE) && !wb_trap_i;
    assign dbg_is_read = (dbg_cmd_q == DBG_READ);

    // State and captured-field registers; reset abandons any access in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            dbg_addr_q   <= '0;
            dbg_cmd_q    <= '0;
            dbg_wdata_q  <= '0;
            dbg_rdata_q  <= '0;
            dbg_err_q    <= 1'b0;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            dbg_addr_q   <= dbg_addr_d;
            dbg_cmd_q    <= dbg_cmd_d;
            dbg_wdata_q  <= dbg_wdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
            dbg_err_q    <= dbg_err_d;
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
        end
    end

    // Next-state logic: request capture, access/retry, handshake and starvation.
    always_comb begin
        state_d      = state_q;
        dbg_addr_d   = dbg_addr_q;
        dbg_cmd_d    = dbg_cmd_q;
        dbg_wdata_d  = dbg_wdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        dbg_err_d    = dbg_err_q;
        starve_cnt_d = starve_cnt_q;
        starve_d     = starve_q;

        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    dbg_addr_d   = dbg_addr_i;
                    dbg_cmd_d    = dbg_cmd_i;
                    dbg_wdata_d  = dbg_wdata_i;
                    starve_cnt_d = '0;
                    starve_d     = 1'b0;
                    state_d      = ACCESS;
                end else if (dbg_req_i) begin
                    // Denied cycle: count up, saturating; flag on reaching the limit.
                    if (starve_cnt_q != LIMIT) begin
                        starve_cnt_d = starve_cnt_q + 8'd1;
                        if (starve_cnt_q + 8'd1 == LIMIT) begin
                            starve_d = 1'b1;
                        end
                    end
                end
            end
            ACCESS: begin
                // A retiring trap suppresses the access; simply retry next cycle.
                if (!wb_trap_i) begin
                    dbg_rdata_d = csr_rdata_i;
                    dbg_err_d   = csr_exception_i;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (!dbg_req_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!dbg_req_i) begin
            starve_cnt_d = '0;
        end
    end

    // CSR-file port mux: captured debug fields in ACCESS, pipeline otherwise.
    always_comb begin
        csr_addr_o           = pipe_csr_addr_i;
        csr_cmd_o            = pipe_csr_cmd_i;
        csr_rs1_zero_o       = pipe_csr_rs1_zero_i;
        csr_wdata_o          = pipe_csr_wdata_i;
        pipe_csr_exception_o = csr_exception_i;

        if (state_q == ACCESS) begin
            csr_addr_o           = dbg_addr_q;
            csr_rs1_zero_o       = dbg_is_read;
            csr_wdata_o          = dbg_is_read ? 32'h0 : dbg_wdata_q;
            csr_cmd_o            = wb_trap_i   ? CMD_NONE
                                 : dbg_is_read ? CMD_SET
                                 :               dbg_cmd_q;
            pipe_csr_exception_o = 1'b0;
        end
    end

    assign pipe_csr_rdata_o = csr_rdata_i;
    assign pipe_stall_o     = starve_q | (state_q == ACCESS);
    assign dbg_ack_o        = (state_q == DONE);
    assign dbg_rdata_o      = dbg_rdata_q;
    assign dbg_err_o        = dbg_err_q;

endmodule
